cell_comm_fa_rx_decoder: RTL and testbench
==========================================

# cell_comm_fa_rx_decoder

Receive-side frame decoder for the cell-communication Aurora links. It consumes the user-side AXIS receive stream of one link (CCW or CW), which has no backpressure, plus the CRC flags carried with the last beat. It validates framing, header and CRC, then emits one decoded fast-acquisition (FA) record per good frame, along with error and statistics counters. One instance sits on each link's user clock, downstream of the Aurora wrapper.

## Interface
Parameters:
- `COUNTER_WIDTH`, 32: width of every statistics counter.
- `MAGIC`, 2'b10: required value of header bits [31:30].

Ports:
- `auroraUserClk` input 1: Aurora user clock. It is the only clock.
- `auroraUserResetN` input 1: reset. Synchronous, active-low.
- `channelUp` input 1: Aurora channel-up status.
- `axisRxTvalid` input 1: receive beat valid. There is no ready signal; every valid beat is consumed.
- `axisRxTlast` input 1: last beat of a frame.
- `axisRxTdata` input 32: receive data.
- `axisRxCRCvalid` input 1: CRC result present. Meaningful only on the tlast beat.
- `axisRxCRCpass` input 1: CRC check passed.
- `statsClear` input 1: single-cycle pulse that zeroes all counters.
- `faValid` output 1: one-cycle strobe marking a new decoded record.
- `faCellIndex` output 6: header bits [29:24].
- `faBpmIndex` output 8: header bits [23:16].
- `faSequence` output 16: header bits [15:0].
- `faX`, `faY`, `faS` outputs 32 each: payload words 1, 2 and 3.
- `goodFrames`, `crcFaults`, `framingFaults`, `headerFaults`, `sequenceFaults` outputs, `COUNTER_WIDTH` each: statistics counters.

## Operation
- The frame is exactly 4 beats: a header, then X, Y, S. `axisRxTlast` is asserted on beat 4 only.
- Cycles with `axisRxTvalid`=0 are ignored in every state.
- The state machine has three states: IDLE, DATA and DROP. A 2-bit `wordCount` and a 3×32 payload buffer support it. Header fields are captured in a staging register.
- IDLE, on a valid beat:
  - tlast=1: increment framingFaults and stay in IDLE.
  - otherwise, header[31:30]≠MAGIC: increment headerFaults and go to DROP.
  - otherwise: capture the header, set wordCount=0 and go to DATA.
- DATA, on a valid beat: store the beat at buffer[wordCount], then:
  - tlast=1 and wordCount=2: the frame is complete.
    - If CRCvalid=1 and CRCpass=1, emit the record and increment goodFrames.
    - Otherwise increment crcFaults and do not emit.
    - Go to IDLE.
  - tlast=1 and wordCount<2: the frame is short. Increment framingFaults and go to IDLE.
  - tlast=0 and wordCount=2: the frame is long. Increment framingFaults and go to DROP.
  - otherwise: increment wordCount.
- DROP: a valid beat with tlast=1 returns to IDLE. No further counts are made for the same frame.
- `channelUp`=0 forces IDLE and clears the partial frame and `seqKnown`. No counter changes and no emission occur. Beats in that cycle are ignored.
- Sequence check, applied on each good frame:
  - If seqKnown=1 and faSequence_new ≠ lastSeq+1 (mod 2^16), increment sequenceFaults. The record is still emitted.
  - On every good frame, set lastSeq to the new sequence number and set seqKnown=1.
  - Wrap from 0xFFFF to 0x0000 is in sequence.
- Counters wrap modulo 2^COUNTER_WIDTH and never saturate.
- `statsClear` zeroes all five counters. A clear in the same cycle as an increment wins: the counter reads 0 on the next cycle. `statsClear` does not affect the FSM, the record outputs or seqKnown.

## Timing
- Reset (auroraUserResetN=0 at a clock edge):
  - state=IDLE, seqKnown=0, lastSeq=0.
  - faValid=0; all fa* data outputs are 0; all counters are 0.
  - Beats presented during reset are dropped.
- Latency: `faValid` and the updated fa* fields appear on the cycle after the accepted tlast beat. `faValid` is high for exactly 1 cycle.
- fa* fields hold their values until the next emission. They change only together with `faValid`.
- Counters update on the cycle after the triggering beat, which is the same cycle as the corresponding `faValid`.
- Maximum emission rate is one per 4 cycles. Back-to-back frames with no idle beats are fully supported: a header may follow a tlast beat in the very next cycle.
- A mid-frame reset or channelUp drop discards the partial frame. The next frame is decoded normally from its header.

## Test plan
- **Good frame.** Send header 0x8A05_0010, then X=0x11, Y=0x22, S=0x33, with tlast+CRCvalid+CRCpass on beat 4. Required: faValid one cycle later; faCellIndex=0x0A, faBpmIndex=0x05, faSequence=0x0010, faX=0x11, faY=0x22, faS=0x33; goodFrames=1.
- **CRC fail and bad header.** Send the same frame with CRCpass=0: required faValid stays 0, crcFaults=1, fa* unchanged. Then send a header 0x4A05_0011 (magic 01) with 3 more beats: required headerFaults=1. Then a good frame: required it decodes.
- **Short and long frames.** Send 2-beat tlast: required framingFaults=1. Send 6 beats with tlast on beat 6: required framingFaults=2, no emission. Send an immediately following good frame: required it is emitted.
- **Sequence checking.** Send good frames with seq 0xFFFE, 0xFFFF, 0x0000, 0x0005. Required: sequenceFaults=1 and goodFrames=4.
- **Channel-up drop mid-frame.** Drop channelUp for 1 cycle after beat 2. Then send seq 0x0100 followed by seq 0x0200. Required: no counts for the aborted frame; seq 0x0100 produces no sequence fault (seqKnown was cleared); seq 0x0200 gives sequenceFaults=1.
- **Simultaneous clear.** Pulse statsClear in the cycle a good-frame tlast is accepted. Required: all counters read 0, and faValid still pulses. Also assert reset mid-frame: required outputs return to 0.

Source files
------------

// File: rtl/cell_comm_fa_rx_decoder.sv
// cell_comm_fa_rx_decoder: validates 4-beat Aurora FA frames and emits decoded records plus fault counters
module cell_comm_fa_rx_decoder #(
  parameter int COUNTER_WIDTH = 32,
  parameter logic [1:0] MAGIC = 2'b10
) (
  input  logic auroraUserClk,
  input  logic auroraUserResetN,
  input  logic channelUp,
  input  logic axisRxTvalid,
  input  logic axisRxTlast,
  input  logic [31:0] axisRxTdata,
  input  logic axisRxCRCvalid,
  input  logic axisRxCRCpass,
  input  logic statsClear,
  output logic faValid,
  output logic [5:0] faCellIndex,
  output logic [7:0] faBpmIndex,
  output logic [15:0] faSequence,
  output logic [31:0] faX,
  output logic [31:0] faY,
  output logic [31:0] faS,
  output logic [COUNTER_WIDTH-1:0] goodFrames,
  output logic [COUNTER_WIDTH-1:0] crcFaults,
  output logic [COUNTER_WIDTH-1:0] framingFaults,
  output logic [COUNTER_WIDTH-1:0] headerFaults,
  output logic [COUNTER_WIDTH-1:0] sequenceFaults
);
  typedef enum logic [1:0] {IDLE, DATA, DROP} stateT;
  localparam logic [COUNTER_WIDTH-1:0] ONE = 1;
  stateT state;
  logic [1:0] wordCount;
  logic [31:0] payload [3];
  logic [29:0] header;
  logic [15:0] lastSeq;
  logic seqKnown;
  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      state <= IDLE;
      wordCount <= '0;
      header <= '0;
      lastSeq <= '0;
      seqKnown <= 1'b0;
      faValid <= 1'b0;
      faCellIndex <= '0;
      faBpmIndex <= '0;
      faSequence <= '0;
      faX <= '0;
      faY <= '0;
      faS <= '0;
      goodFrames <= '0;
      crcFaults <= '0;
      framingFaults <= '0;
      headerFaults <= '0;
      sequenceFaults <= '0;
    end else begin
      faValid <= 1'b0;
      if (!channelUp) begin
        state <= IDLE;
        wordCount <= '0;
        seqKnown <= 1'b0;
      end else if (axisRxTvalid) begin
        case (state)
          IDLE:
            if (axisRxTlast) framingFaults <= framingFaults + ONE;
            else if (axisRxTdata[31:30] != MAGIC) begin
              headerFaults <= headerFaults + ONE;
              state <= DROP;
            end else begin
              header <= axisRxTdata[29:0];
              wordCount <= '0;
              state <= DATA;
            end
          DATA: begin
            payload[wordCount] <= axisRxTdata;
            if (axisRxTlast) begin
              state <= IDLE;
              if (wordCount != 2'd2) framingFaults <= framingFaults + ONE;
              else if (axisRxCRCvalid && axisRxCRCpass) begin
                // S is the current beat, so it bypasses the buffer
                faValid <= 1'b1;
                faCellIndex <= header[29:24];
                faBpmIndex <= header[23:16];
                faSequence <= header[15:0];
                faX <= payload[0];
                faY <= payload[1];
                faS <= axisRxTdata;
                goodFrames <= goodFrames + ONE;
                if (seqKnown && header[15:0] != lastSeq + 16'd1) sequenceFaults <= sequenceFaults + ONE;
                lastSeq <= header[15:0];
                seqKnown <= 1'b1;
              end else crcFaults <= crcFaults + ONE;
            end else if (wordCount == 2'd2) begin
              framingFaults <= framingFaults + ONE;
              state <= DROP;
            end else wordCount <= wordCount + 2'd1;
          end
          default:
            if (axisRxTlast) state <= IDLE;
        endcase
      end
      // clear overrides any increment made in the same cycle
      if (statsClear) begin
        goodFrames <= '0;
        crcFaults <= '0;
        framingFaults <= '0;
        headerFaults <= '0;
        sequenceFaults <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cell_comm_fa_rx_decoder.sv
// tb_cell_comm_fa_rx_decoder: directed scoreboard bench for the FA receive decoder
module tb_cell_comm_fa_rx_decoder;
  typedef struct packed {
    logic [5:0] c;
    logic [7:0] b;
    logic [15:0] q;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] s;
  } recT;
  logic clk = 1'b0;
  logic rstN, chUp, tvalid, tlast, crcV, crcP, clr;
  logic [31:0] tdata;
  logic faValid;
  logic [5:0] faCellIndex;
  logic [7:0] faBpmIndex;
  logic [15:0] faSequence;
  logic [31:0] faX, faY, faS;
  logic [31:0] goodFrames, crcFaults, framingFaults, headerFaults, sequenceFaults;
  recT sb [$];
  recT expRec;
  logic prevValid = 1'b0;
  int compared = 0;
  int mismatched = 0;

  cell_comm_fa_rx_decoder dut (
    .auroraUserClk(clk), .auroraUserResetN(rstN), .channelUp(chUp),
    .axisRxTvalid(tvalid), .axisRxTlast(tlast), .axisRxTdata(tdata),
    .axisRxCRCvalid(crcV), .axisRxCRCpass(crcP), .statsClear(clr),
    .faValid(faValid), .faCellIndex(faCellIndex), .faBpmIndex(faBpmIndex),
    .faSequence(faSequence), .faX(faX), .faY(faY), .faS(faS),
    .goodFrames(goodFrames), .crcFaults(crcFaults), .framingFaults(framingFaults),
    .headerFaults(headerFaults), .sequenceFaults(sequenceFaults)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCnt(input string tag, input int g, input int c, input int f, input int h, input int s);
    check({tag, "_cnt"}, {goodFrames, crcFaults, framingFaults, headerFaults},
          {g[31:0], c[31:0], f[31:0], h[31:0]});
    check({tag, "_seqFaults"}, {96'd0, sequenceFaults}, {96'd0, s[31:0]});
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic cv, input logic cp);
    tvalid = 1'b1; tdata = d; tlast = l; crcV = cv; crcP = cp;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0; crcV = 1'b0; crcP = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] h, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] s, input logic cp, input logic doClr);
    if (cp) sb.push_back('{h[29:24], h[23:16], h[15:0], x, y, s});
    beat(h, 1'b0, 1'b0, 1'b0);
    beat(x, 1'b0, 1'b0, 1'b0);
    beat(y, 1'b0, 1'b0, 1'b0);
    clr = doClr;
    beat(s, 1'b1, 1'b1, cp);
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (faValid) begin
      check("sbNonEmpty", {127'd0, sb.size() != 0}, 128'd1);
      if (sb.size() != 0) begin
        expRec = sb.pop_front();
        check("record", {2'd0, faCellIndex, faBpmIndex, faSequence, faX, faY, faS}, {2'd0, expRec});
      end
      check("singlePulse", {127'd0, prevValid}, 128'd0);
    end
    prevValid = faValid;
  end

  initial begin
    rstN = 1'b0; chUp = 1'b1; clr = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; crcV = 1'b0; crcP = 1'b0;
    @(negedge clk);
    beat(32'h8A05_0010, 1'b0, 1'b0, 1'b0);
    beat(32'h0000_0011, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("resetRecord", {faValid, faCellIndex, faBpmIndex, faSequence, faX, faY, faS}, 128'd0);
    checkCnt("reset", 0, 0, 0, 0, 0);
    rstN = 1'b1;
    idle(2);
    // good frame
    frame(32'h8A05_0010, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0);
    checkCnt("good", 1, 0, 0, 0, 0);
    idle(2);
    // CRC failure leaves outputs untouched
    frame(32'h8A05_0010, 32'h44, 32'h55, 32'h66, 1'b0, 1'b0);
    checkCnt("crcFail", 1, 1, 0, 0, 0);
    check("crcFailHold", {32'd0, faX, faY, faS}, {32'd0, 32'h11, 32'h22, 32'h33});
    // bad magic
    frame(32'h4A05_0011, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
    checkCnt("badHeader", 1, 1, 0, 1, 0);
    frame(32'h8A05_0011, 32'hA1, 32'hA2, 32'hA3, 1'b1, 1'b0);
    checkCnt("afterBad", 2, 1, 0, 1, 0);
    idle(1);
    // short then long frame, then back-to-back good frame
    beat(32'h8000_0012, 1'b0, 1'b0, 1'b0);
    beat(32'h0000_0001, 1'b1, 1'b1, 1'b1);
    checkCnt("short", 2, 1, 1, 1, 0);
    beat(32'h8000_0012, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) beat(i, 1'b0, 1'b0, 1'b0);
    beat(32'h5, 1'b1, 1'b1, 1'b1);
    checkCnt("long", 2, 1, 2, 1, 0);
    frame(32'h8102_0012, 32'hB1, 32'hB2, 32'hB3, 1'b1, 1'b0);
    checkCnt("backToBack", 3, 1, 2, 1, 0);
    // sequence wrap from a fresh reset
    rstN = 1'b0;
    idle(1);
    rstN = 1'b1;
    frame(32'h8000_FFFE, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0);
    frame(32'h8000_FFFF, 32'h4, 32'h5, 32'h6, 1'b1, 1'b0);
    frame(32'h8000_0000, 32'h7, 32'h8, 32'h9, 1'b1, 1'b0);
    checkCnt("seqWrap", 3, 0, 0, 0, 0);
    frame(32'h8000_0005, 32'hA, 32'hB, 32'hC, 1'b1, 1'b0);
    checkCnt("seqJump", 4, 0, 0, 0, 1);
    // channel drop mid-frame
    beat(32'h8000_0099, 1'b0, 1'b0, 1'b0);
    beat(32'h0000_00C1, 1'b0, 1'b0, 1'b0);
    chUp = 1'b0;
    beat(32'h0000_00C2, 1'b0, 1'b0, 1'b0);
    chUp = 1'b1;
    idle(1);
    checkCnt("chDrop", 4, 0, 0, 0, 1);
    frame(32'h8000_0100, 32'hD1, 32'hD2, 32'hD3, 1'b1, 1'b0);
    checkCnt("seqForgotten", 5, 0, 0, 0, 1);
    frame(32'h8000_0200, 32'hE1, 32'hE2, 32'hE3, 1'b1, 1'b0);
    checkCnt("seqAfterDrop", 6, 0, 0, 0, 2);
    // clear coincident with a good frame
    frame(32'h8000_0201, 32'hF1, 32'hF2, 32'hF3, 1'b1, 1'b1);
    checkCnt("clearWins", 0, 0, 0, 0, 0);
    idle(1);
    checkCnt("clearHold", 0, 0, 0, 0, 0);
    // reset mid-frame
    beat(32'h8000_0300, 1'b0, 1'b0, 1'b0);
    beat(32'h0000_0301, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    idle(1);
    check("midReset", {faValid, faCellIndex, faBpmIndex, faSequence, faX, faY, faS}, 128'd0);
    rstN = 1'b1;
    frame(32'h8304_0301, 32'h91, 32'h92, 32'h93, 1'b1, 1'b0);
    checkCnt("afterReset", 1, 0, 0, 0, 0);
    idle(4);
    check("sbDrained", {96'd0, sb.size()}, 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
